// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel push-button debouncer.
// Each raw pin passes a 2-FF synchroniser and a per-channel stability counter;
// a level change is accepted only after DEBOUNCE_DELAY consecutive cycles that
// disagree with the current debounced level.
// Outputs are plain registered pulses with no handshake: press/released are
// high for exactly one cycle per event and are never high together on one
// channel; any_press is the OR of press in the same cycle.
// Optional feature: define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses
// while a button is held.
// The release pulse port is called 'released' because 'release' is a reserved
// word in SystemVerilog.
module debounce_multi #(
  parameter int CHANNELS       = 4,
  parameter int DEBOUNCE_DELAY = 500_000,
  parameter int CNT_W          = 20,
  parameter int ACTIVE_LOW     = 1,
  parameter int REPEAT_DELAY   = 50_000_000,
  parameter int REPEAT_RATE    = 10_000_000,
  parameter int RPT_W          = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] released,
  output logic                any_press
);

  // Synchroniser flops reset to the idle pin level so reset never looks like a press.
  localparam logic [CHANNELS-1:0] IDLE_PIN = {CHANNELS{ACTIVE_LOW != 0}};
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_DELAY - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] act;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] rpt_fire;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  assign act       = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  assign any_press = |press;

  // A channel accepts its new level when it has disagreed for DEBOUNCE_DELAY cycles.
  always_comb begin
    accept = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      accept[i] = (act[i] != level[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Synchroniser, stability counters, debounced level and event pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= IDLE_PIN;
      sync2    <= IDLE_PIN;
      level    <= '0;
      press    <= '0;
      released <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= button;
      sync2    <= sync1;
      press    <= (accept & act) | rpt_fire;
      released <= accept & ~act;
      for (int i = 0; i < CHANNELS; i++) begin
        if (act[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          level[i] <= act[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  // armed=0 waits for the first repeat (REPEAT_DELAY), armed=1 for later ones (REPEAT_RATE).
  logic [RPT_W-1:0]    rcnt [CHANNELS];
  logic [CHANNELS-1:0] armed;

  // Repeat fires while held; an accepted release in the same cycle always wins.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rpt_fire[i] = level[i] && !accept[i] &&
                    (rcnt[i] == (armed[i] ? RPT_W'(REPEAT_RATE - 1)
                                          : RPT_W'(REPEAT_DELAY - 1)));
    end
  end

  // Repeat counters: cleared on press, on release and whenever the level is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        rcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!level[i] || accept[i]) begin
          rcnt[i]  <= '0;
          armed[i] <= 1'b0;
        end else if (rpt_fire[i]) begin
          rcnt[i]  <= '0;
          armed[i] <= 1'b1;
        end else begin
          rcnt[i] <= rcnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios followed by random button
// activity and occasional resets, checked against a reference model.
module tb_debounce_multi;

  localparam int CH = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam int W  = 32 + 2 * CH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] button = '1;
  logic [CH-1:0] level, press, released;
  logic          any_press;

  // Clock and DUT.
  always #5 clk = ~clk;

  debounce_multi #(
    .CHANNELS(CH), .DEBOUNCE_DELAY(D), .CNT_W(8), .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .RPT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button), .level(level),
    .press(press), .released(released), .any_press(any_press)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];

  // Model state: raw samples in flight, recent active samples, accepted level.
  logic [CH-1:0] samp_q[$];
  logic [CH-1:0] act_hist[$];
  logic [CH-1:0] m_level = '0;
  int            next_rpt[CH];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Reference model: the active value seen at edge t is the inverted raw pin
  // from edge t-2; a level flips once the last D active samples all disagree
  // with it. Held presses repeat RD edges after the press and then every RR.
  always @(posedge clk) begin : model
    logic [CH-1:0] a, pv, rv;
    bit flip;
    cyc++;
    if (!rst_n) begin
      samp_q.delete();
      samp_q.push_back('1);
      samp_q.push_back('1);
      act_hist.delete();
      m_level = '0;
    end else begin
      a = ~samp_q.pop_front();
      samp_q.push_back(button);
      act_hist.push_back(a);
      if (act_hist.size() > D) void'(act_hist.pop_front());
      pv = '0;
      rv = '0;
      for (int i = 0; i < CH; i++) begin
        flip = (act_hist.size() == D);
        for (int j = 0; j < act_hist.size(); j++)
          if (act_hist[j][i] == m_level[i]) flip = 0;
        if (flip) begin
          if (!m_level[i]) begin
            pv[i] = 1'b1;
            next_rpt[i] = cyc + RD;
          end else begin
            rv[i] = 1'b1;
          end
          m_level[i] = ~m_level[i];
        end
`ifdef DEBOUNCE_REPEAT_EN
        else if (m_level[i] && cyc == next_rpt[i]) begin
          pv[i] = 1'b1;
          next_rpt[i] = cyc + RR;
        end
`endif
      end
      if ((pv | rv) != '0) exp_q.push_back({cyc[31:0], pv, rv});
    end
  end

  // Monitor: compares outputs each negedge against the queued expected events.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    logic [CH-1:0] ep, er;
    ep = '0;
    er = '0;
    if (exp_q.size() != 0 && exp_q[0][W-1 -: 32] == cyc[31:0]) begin
      e  = exp_q.pop_front();
      ep = e[2*CH-1:CH];
      er = e[CH-1:0];
    end
    chk("press", 32'(press), 32'(ep));
    chk("release", 32'(released), 32'(er));
    chk("any_press", 32'(any_press), 32'(|ep));
    chk("level", 32'(level), 32'(m_level));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus.
  initial begin : stim
    int hold[CH];
    rst_n  = 1'b0;
    button = '1;
    cycles(3);
    rst_n = 1'b1;
    cycles(4);

    // Short low pulse then fast toggling: no event expected.
    button[0] = 1'b0; cycles(3);
    button[0] = 1'b1; cycles(1);
    for (int k = 0; k < 6; k++) begin
      button[0] = ~button[0];
      cycles(2);
    end
    button[0] = 1'b1; cycles(8);

    // Clean press held long enough for auto-repeats, then release.
    button[0] = 1'b0; cycles(30);
    button[0] = 1'b1; cycles(10);

    // Two channels pressed in the same cycle, then released.
    button[1] = 1'b0; button[3] = 1'b0; cycles(10);
    button[1] = 1'b1; button[3] = 1'b1; cycles(10);

    // Reset while a press is mid-count, button kept held.
    button[2] = 1'b0; cycles(4);
    rst_n = 1'b0; cycles(1);
    rst_n = 1'b1; cycles(14);
    button[2] = 1'b1; cycles(10);

    // Random activity on all channels with occasional resets.
    for (int i = 0; i < CH; i++) hold[i] = 1;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < CH; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          button[i] = 1'($urandom_range(0, 1));
          hold[i]   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                  : $urandom_range(3, 20);
        end
      end
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cycles(1);
    end

    rst_n  = 1'b1;
    button = '1;
    cycles(20);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
